// File: rtl/runtime_snapshot_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : runtime_snapshot_buffer_pkg
// Purpose  : Shared types and constants for the runtime snapshot buffer.
// Revision : 1.0 - initial release
// ============================================================================
package runtime_snapshot_buffer_pkg;

  localparam int WORD_WIDTH             = 32;
  localparam int SNAP_DEPTH_DEFAULT     = 8;
  localparam int SNAP_SEQ_WIDTH_DEFAULT = 8;

  typedef logic [WORD_WIDTH-1:0] word_type;

  // Snapshot record at the default tag width
  typedef struct packed {
    word_type                          runtime;
    logic [SNAP_SEQ_WIDTH_DEFAULT-1:0] seq;
  } snapshot_type;

  // Unsigned full-width maximum of two runtime words
  function automatic word_type max_word(input word_type a, input word_type b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/runtime_snapshot_buffer_snapshot_fifo.sv
`default_nettype none
// ============================================================================
// Module   : snapshot_fifo
// Purpose  : Synchronous first-word-fall-through FIFO with a registered head
//            word, wrap-bit pointers and a registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module snapshot_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  output logic                     valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             valid_q,  valid_d;
  logic [WIDTH-1:0] head_q,   head_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  // Full when indices match but wrap bits differ; empty when pointers equal
  always_comb begin
    full    = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    empty   = (wr_ptr_q == rd_ptr_q);
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // Next pointers, occupancy and head word; a push landing at the new read
  // pointer bypasses the array so the head is valid one cycle after the push
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    level_d  = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    valid_d  = (level_d != '0);
    head_d   = head_q;
    if (valid_d) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
        head_d = wr_data;
      end else begin
        head_d = mem_q[rd_ptr_d[AW-1:0]];
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  // Storage array write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign valid   = valid_q;
  assign rd_data = head_q;
  assign level   = level_q;

endmodule
`default_nettype wire

// File: rtl/runtime_snapshot_buffer.sv
`default_nettype none
// ============================================================================
// Module   : runtime_snapshot_buffer
// Purpose  : Captures runtime counter values on each synch pulse into a
//            tagged FIFO and keeps peak-runtime / dropped-capture statistics.
// Revision : 1.0 - initial release
// ============================================================================
module runtime_snapshot_buffer
  import runtime_snapshot_buffer_pkg::*;
#(
  parameter int DEPTH      = SNAP_DEPTH_DEFAULT,
  parameter int SEQ_WIDTH  = SNAP_SEQ_WIDTH_DEFAULT,
  parameter int DROP_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     synch,
  input  word_type                 ctr_val,
  output logic                     snap_valid,
  input  logic                     snap_ready,
  output word_type                 snap_data,
  output logic [SEQ_WIDTH-1:0]     snap_seq,
  output logic [$clog2(DEPTH):0]   level,
  output word_type                 max_runtime,
  output logic [DROP_WIDTH-1:0]    drop_cnt,
  output logic                     ovf,
  input  logic                     clr_stats
);

  localparam int EW = WORD_WIDTH + SEQ_WIDTH;

  logic [SEQ_WIDTH-1:0]  seq_q,  seq_d;
  word_type              max_q,  max_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic                  ovf_q,  ovf_d;

  logic                  fifo_full;
  logic                  fifo_valid;
  logic [EW-1:0]         fifo_rd_data;
  logic                  pop;
  logic                  drop;

  snapshot_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (synch),
    .pop     (pop),
    .wr_data ({ctr_val, seq_q}),
    .full    (fifo_full),
    .valid   (fifo_valid),
    .rd_data (fifo_rd_data),
    .level   (level)
  );

  // Statistics and tag update; clr_stats zeroes the base before this
  // cycle's capture is folded in, so a same-cycle capture still counts
  always_comb begin
    pop    = fifo_valid & snap_ready;
    drop   = synch & fifo_full & ~pop;
    seq_d  = seq_q + {{(SEQ_WIDTH-1){1'b0}}, synch};
    max_d  = clr_stats ? '0 : max_q;
    drop_d = clr_stats ? '0 : drop_q;
    ovf_d  = clr_stats ? 1'b0 : ovf_q;
    if (synch) begin
      max_d = max_word(max_d, ctr_val);
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != {DROP_WIDTH{1'b1}}) begin
        drop_d = drop_d + 1'b1;
      end
    end
  end

  // Tag and statistics registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_q  <= '0;
      max_q  <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      seq_q  <= seq_d;
      max_q  <= max_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign snap_valid  = fifo_valid;
  assign snap_data   = fifo_rd_data[EW-1:SEQ_WIDTH];
  assign snap_seq    = fifo_rd_data[SEQ_WIDTH-1:0];
  assign max_runtime = max_q;
  assign drop_cnt    = drop_q;
  assign ovf         = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_runtime_snapshot_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_runtime_snapshot_buffer
// Purpose  : Directed self-checking bench for runtime_snapshot_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_runtime_snapshot_buffer;

  logic        clk;
  logic        rst;
  logic        synch;
  logic [31:0] ctr_val;
  logic        snap_valid;
  logic        snap_ready;
  logic [31:0] snap_data;
  logic [7:0]  snap_seq;
  logic [3:0]  level;
  logic [31:0] max_runtime;
  logic [7:0]  drop_cnt;
  logic        ovf;
  logic        clr_stats;

  int n_checks = 0;
  int n_fail   = 0;

  runtime_snapshot_buffer #(
    .DEPTH      (8),
    .SEQ_WIDTH  (8),
    .DROP_WIDTH (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .synch       (synch),
    .ctr_val     (ctr_val),
    .snap_valid  (snap_valid),
    .snap_ready  (snap_ready),
    .snap_data   (snap_data),
    .snap_seq    (snap_seq),
    .level       (level),
    .max_runtime (max_runtime),
    .drop_cnt    (drop_cnt),
    .ovf         (ovf),
    .clr_stats   (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: inputs change and outputs are sampled at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; synch = 1'b1; ctr_val = 32'd99; snap_ready = 1'b0; clr_stats = 1'b0;
    @(negedge clk);

    // Reset held two cycles with synch high: nothing captured
    tick(); tick();
    check("rst_valid", 64'(snap_valid), 64'd0);
    check("rst_data",  64'(snap_data),  64'd0);
    check("rst_seq",   64'(snap_seq),   64'd0);
    check("rst_level", 64'(level),      64'd0);
    check("rst_max",   64'(max_runtime),64'd0);
    check("rst_drop",  64'(drop_cnt),   64'd0);
    check("rst_ovf",   64'(ovf),        64'd0);
    rst = 1'b1; synch = 1'b0;
    tick();

    // Single capture, held while not ready, then popped
    ctr_val = 32'd37; synch = 1'b1;
    tick();
    synch = 1'b0; ctr_val = 32'd4444;
    check("single_valid", 64'(snap_valid), 64'd1);
    check("single_data",  64'(snap_data),  64'd37);
    check("single_seq",   64'(snap_seq),   64'd0);
    check("single_level", 64'(level),      64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_data", 64'(snap_data), 64'd37);
      check("hold_seq",  64'(snap_seq),  64'd0);
      check("hold_valid",64'(snap_valid),64'd1);
    end
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    check("pop_valid", 64'(snap_valid), 64'd0);
    check("pop_level", 64'(level),      64'd0);
    check("pop_max",   64'(max_runtime),64'd37);

    // Reset, then fill past full: two captures dropped
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      ctr_val = 32'(i); synch = 1'b1;
      tick();
    end
    synch = 1'b0;
    check("fill_level", 64'(level),       64'd8);
    check("fill_drop",  64'(drop_cnt),    64'd2);
    check("fill_ovf",   64'(ovf),         64'd1);
    check("fill_max",   64'(max_runtime), 64'd10);
    snap_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 64'(snap_valid), 64'd1);
      check("drain_data",  64'(snap_data),  64'(i + 1));
      check("drain_seq",   64'(snap_seq),   64'(i));
      tick();
    end
    snap_ready = 1'b0;
    check("drained_valid", 64'(snap_valid), 64'd0);
    check("drained_level", 64'(level),      64'd0);
    ctr_val = 32'd55; synch = 1'b1;
    tick();
    synch = 1'b0;
    check("gap_seq",  64'(snap_seq),  64'd10);
    check("gap_data", 64'(snap_data), 64'd55);
    snap_ready = 1'b1; tick(); snap_ready = 1'b0;

    // Full with simultaneous push and pop: no drop, new entry kept
    for (int i = 0; i < 8; i++) begin
      ctr_val = 32'(100 + i); synch = 1'b1;
      tick();
    end
    check("full_level", 64'(level),    64'd8);
    check("full_drop",  64'(drop_cnt), 64'd2);
    ctr_val = 32'd200; synch = 1'b1; snap_ready = 1'b1;
    tick();
    synch = 1'b0; snap_ready = 1'b0;
    check("pp_level", 64'(level),     64'd8);
    check("pp_drop",  64'(drop_cnt),  64'd2);
    check("pp_head",  64'(snap_data), 64'd101);
    snap_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_data", 64'(snap_data), (i == 7) ? 64'd200 : 64'(101 + i));
      check("pp_seq",  64'(snap_seq),  64'(12 + i));
      tick();
    end
    snap_ready = 1'b0;
    check("pp_empty", 64'(level), 64'd0);

    // Statistics: clear, peak tracking, clear with same-cycle capture
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    check("clr_max",  64'(max_runtime), 64'd0);
    check("clr_drop", 64'(drop_cnt),    64'd0);
    check("clr_ovf",  64'(ovf),         64'd0);
    ctr_val = 32'd5;   synch = 1'b1; tick();
    ctr_val = 32'd900; tick();
    ctr_val = 32'd12;  tick();
    synch = 1'b0;
    check("peak_max", 64'(max_runtime), 64'd900);
    clr_stats = 1'b1; synch = 1'b1; ctr_val = 32'd3;
    tick();
    clr_stats = 1'b0;
    check("clrsyn_max",   64'(max_runtime), 64'd3);
    check("clrsyn_drop",  64'(drop_cnt),    64'd0);
    check("clrsyn_ovf",   64'(ovf),         64'd0);
    check("clrsyn_level", 64'(level),       64'd4);
    ctr_val = 32'd1;
    for (int i = 0; i < 4; i++) tick();
    ctr_val = 32'd2;
    tick();
    check("sat_drop", 64'(drop_cnt), 64'd1);
    check("sat_ovf",  64'(ovf),      64'd1);
    clr_stats = 1'b1; ctr_val = 32'd3;
    tick();
    clr_stats = 1'b0; synch = 1'b0;
    check("clrfull_drop", 64'(drop_cnt),    64'd1);
    check("clrfull_ovf",  64'(ovf),         64'd1);
    check("clrfull_max",  64'(max_runtime), 64'd3);

    // Mid-stream reset with a full FIFO discards everything
    rst = 1'b0; tick(); rst = 1'b1;
    check("mrst_level", 64'(level),      64'd0);
    check("mrst_valid", 64'(snap_valid), 64'd0);

    // Sequence wrap: push every cycle with ready held high
    synch = 1'b1; snap_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      ctr_val = 32'(i);
      tick();
      check("wrap_level", 64'(level),    64'd1);
      check("wrap_seq",   64'(snap_seq), 64'(i % 256));
    end
    synch = 1'b0; snap_ready = 1'b0;
    check("wrap_last_seq",  64'(snap_seq),  64'd0);
    check("wrap_last_data", 64'(snap_data), 64'd256);
    rst = 1'b0; tick(); rst = 1'b1;
    check("wrst_level", 64'(level), 64'd0);
    ctr_val = 32'd77; synch = 1'b1;
    tick();
    synch = 1'b0;
    check("wrst_seq",  64'(snap_seq),  64'd0);
    check("wrst_data", 64'(snap_data), 64'd77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
